// File: rtl/ram_controller.sv
// rtl/ram_controller.sv - single-port RAM behind a start/done handshake FSM; optional err output via RAM_CTRL_ERR_EN
module ram_controller #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  rw,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic [DATA_WIDTH-1:0] read_data,
`ifdef RAM_CTRL_ERR_EN
    output logic                  err,
`endif
    output logic                  done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_DONE
    } state_t;

    state_t                  state;
    logic                    rw_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic                    in_range;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    assign in_range = (32'(addr_q) < 32'(DEPTH));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            done      <= 1'b0;
            read_data <= '0;
            rw_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
`ifdef RAM_CTRL_ERR_EN
            err       <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        rw_q    <= rw;
                        addr_q  <= address;
                        wdata_q <= write_data;
                        state   <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (!rw_q) begin
                        read_data <= in_range ? mem[addr_q] : '0;
                    end
                    state <= S_DONE;
                end
                S_DONE: begin
                    // done follows start here so a held start yields exactly one access
                    if (start) begin
                        done <= 1'b1;
`ifdef RAM_CTRL_ERR_EN
                        err  <= ~in_range;
`endif
                    end else begin
                        done  <= 1'b0;
`ifdef RAM_CTRL_ERR_EN
                        err   <= 1'b0;
`endif
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // RAM is unreset; an async reset forces IDLE before any pending ACCESS edge
    always_ff @(posedge clk) begin
        if (state == S_ACCESS && rw_q && in_range) begin
            mem[addr_q] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_ram_controller.sv
// tb/tb_ram_controller.sv - randomized scoreboard bench for ram_controller (DEPTH=200)
module tb_ram_controller;

    localparam int AW    = 8;
    localparam int DW    = 8;
    localparam int DEPTH = 200;

    logic          clk;
    logic          rst;
    logic          start;
    logic          rw;
    logic [AW-1:0] address;
    logic [DW-1:0] write_data;
    logic [DW-1:0] read_data;
    logic          done;
`ifdef RAM_CTRL_ERR_EN
    logic          err;
`endif

    ram_controller #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .rw         (rw),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
`ifdef RAM_CTRL_ERR_EN
        .err        (err),
`endif
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] rd;
        bit            known;
        bit            err;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] model_mem [int];
    logic [DW-1:0] last_read;
    bit            last_known;
    int            vectors;
    int            miscompares;
    logic          done_d;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // One complete host transaction; the expected response is queued for the monitor
    task automatic access(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d, input int hold);
        exp_t e;
        int   cycles;
        if (w) begin
            if (int'(a) < DEPTH) model_mem[int'(a)] = d;
        end else if (int'(a) >= DEPTH) begin
            last_read  = '0;
            last_known = 1'b1;
        end else if (model_mem.exists(int'(a))) begin
            last_read  = model_mem[int'(a)];
            last_known = 1'b1;
        end else begin
            last_known = 1'b0;
        end
        e.rd    = last_read;
        e.known = last_known;
        e.err   = (int'(a) >= DEPTH);
        exp_q.push_back(e);

        rw = w; address = a; write_data = d; start = 1'b1;
        cycles = 0;
        do begin
            @(posedge clk); #1;
            cycles++;
            rw = 1'($urandom); address = AW'($urandom); write_data = DW'($urandom);
        end while (!done && cycles < 8);
        check("latency", cycles, 3);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("done_hold", {31'd0, done}, 1);
        end
        start = 1'b0;
        @(posedge clk); #1;
        check("done_fall", {31'd0, done}, 0);
    endtask

    always @(negedge clk) begin
        if (done && !done_d) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (e.known) check("read_data", {24'd0, read_data}, {24'd0, e.rd});
`ifdef RAM_CTRL_ERR_EN
                check("err", {31'd0, err}, {31'd0, e.err});
`endif
            end
        end
        done_d = done;
    end

    initial begin
        vectors = 0; miscompares = 0; done_d = 1'b0;
        last_read = '0; last_known = 1'b1;
        rst = 1'b0; start = 1'b0; rw = 1'b0; address = '0; write_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_done", {31'd0, done}, 0);
        check("reset_read_data", {24'd0, read_data}, 0);
        rst = 1'b1;
        @(posedge clk); #1;

        access(1, 8'h10, 8'hAB, 0);
        access(0, 8'h10, 8'h00, 0);
        access(1, 8'h20, 8'hCD, 1);
        access(0, 8'h20, 8'h00, 0);
        access(0, 8'h10, 8'h00, 5);
        access(1, 8'h30, 8'h55, 2);
        access(0, 8'hF0, 8'h00, 0);
        access(1, 8'hF0, 8'h77, 0);
        access(0, 8'hF0, 8'h00, 0);
        access(0, 8'hC7, 8'h00, 0);

        for (int n = 0; n < 40; n++) begin
            logic [AW-1:0] a;
            a = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 15)) : AW'($urandom_range(0, 255));
            access(bit'($urandom_range(0, 1)), a, DW'($urandom), $urandom_range(0, 3));
        end

        access(1, 8'h33, 8'h11, 0);
        access(0, 8'h20, 8'h00, 0);
        rw = 1'b1; address = 8'h33; write_data = 8'h99; start = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("midreset_done", {31'd0, done}, 0);
        check("midreset_read_data", {24'd0, read_data}, 0);
        last_read = '0; last_known = 1'b1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        access(0, 8'h33, 8'h00, 0);
        access(1, 8'h05, 8'h00, 0);

        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
